// File: rtl/xosera_pkg.sv
// xosera_pkg: shared Xosera constants and types (package xv).
// Holds boot/reset sequencing defaults and the boot controller state enum.
package xv;

    localparam int BOOT_LOCK_FILTER   = 16;
    localparam int BOOT_RESET_CYCLES  = 1024;
    localparam int BOOT_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        LOCK_WAIT,
        STRETCH,
        RUN,
        SETTLE,
        BOOT
    } boot_state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/xosera_boot_ctrl_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, synchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/xosera_boot_ctrl.sv
// xosera_boot_ctrl: PLL-lock qualified system reset plus reconfig-to-warm-boot sequencer.
// All outputs are registered from the next state, so they change on the same edge as the state.
module xosera_boot_ctrl
    import xv::*;
#(
    parameter int LOCK_FILTER   = BOOT_LOCK_FILTER,
    parameter int RESET_CYCLES  = BOOT_RESET_CYCLES,
    parameter int SETTLE_CYCLES = BOOT_SETTLE_CYCLES
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       pll_lock_i,
    input  logic       reconfig_i,
    input  logic [1:0] boot_select_i,
    output logic       reset_o,
    output logic       boot_o,
    output logic [1:0] boot_s_o,
    output logic       running_o
);
    localparam int CW = $clog2(max3(LOCK_FILTER, RESET_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CW-1:0] LF_C = CW'(LOCK_FILTER);
    localparam logic [CW-1:0] RC_C = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] SC_C = CW'(SETTLE_CYCLES);

    boot_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, inc;
    logic [1:0]    boot_s_q, boot_s_d;
    logic          reset_q, boot_q, running_q;
    logic          lock_s;

    sync_2ff u_sync (
        .clk    (clk),
        .reset_i(reset_i),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    assign inc = cnt_q + CW'(1);

    // STRETCH and SETTLE exit on the incremented value so the state change lands on the final counted edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        boot_s_d = boot_s_q;
        case (state_q)
            LOCK_WAIT: begin
                if (lock_s && cnt_q == LF_C) state_d = STRETCH;
                else if (lock_s) cnt_d = inc;
            end
            STRETCH: begin
                if (!lock_s) state_d = LOCK_WAIT;
                else if (inc == RC_C) state_d = RUN;
                else cnt_d = inc;
            end
            RUN: begin
                if (!lock_s) state_d = LOCK_WAIT;
                else if (reconfig_i) begin
                    state_d  = SETTLE;
                    boot_s_d = boot_select_i;
                end
            end
            SETTLE: begin
                if (inc == SC_C) state_d = BOOT;
                else cnt_d = inc;
            end
            BOOT: state_d = BOOT;
            default: state_d = LOCK_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= LOCK_WAIT;
            cnt_q     <= '0;
            boot_s_q  <= 2'b00;
            reset_q   <= 1'b1;
            boot_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            boot_s_q  <= boot_s_d;
            reset_q   <= state_d != RUN;
            boot_q    <= state_d == BOOT;
            running_q <= state_d == RUN;
        end
    end

    assign reset_o   = reset_q;
    assign boot_o    = boot_q;
    assign boot_s_o  = boot_s_q;
    assign running_o = running_q;

endmodule
